idct_mac_accumulator: RTL and testbench
=======================================

# idct_mac_accumulator

- Sits directly downstream of the configurable multiplier wrapper in the IDCT datapath.
- Consumes the 32-bit product stream `P` one product per cycle and sums groups of TAPS products into one IDCT output.
- Applies pass-dependent rounding, shift and saturation to each sum, then delivers the 16-bit results through a 2-entry output buffer with a valid/ready handshake.
- Tags each result with its coefficient index within the 8x8 block.

## Interface
- `TAPS`, 8, products summed per output (power of two, 2..16)
- `ACC_WIDTH`, 40, accumulator width (signed)
- `OUT_WIDTH`, 16, output sample width (signed)
- `ROW_SHIFT`, 3, right shift applied to row-pass sums (>=1)
- `COL_SHIFT`, 6, right shift applied to column-pass sums (>=1)

- `clk`  in  1  clock; all state updates on rising edge
- `rstN`  in  1  asynchronous reset, active-low
- `state`  in  3  pass encoding shared with the multiplier; 3'b010 selects a row pass, any other value selects a column pass
- `P`  in  32  signed product from the multiplier
- `p_valid`  in  1  `P` holds a valid product this cycle
- `p_ready`  out  1  block can accept a product this cycle
- `flush`  in  1  synchronous abort of the partial group
- `out_data`  out  OUT_WIDTH  rounded, saturated result at the buffer head
- `out_idx`  out  6  coefficient index (0..63) of `out_data`
- `out_last`  out  1  `out_idx == 63`
- `out_valid`  out  1  buffer non-empty
- `out_ready`  in  1  consumer accepts the head
- `sat_sticky`  out  1  set when any result saturated; cleared only by reset

## Operation
**Product acceptance**
- A product is accepted on an edge where `p_valid && p_ready`.
- `tap_cnt` counts 0..TAPS-1.

**Accumulation**
- On an accepted product with `tap_cnt == 0`:
  - `acc` is loaded with sign-extended `P`.
  - `pass` is latched from `state`: 1 = row, when `state == 3'b010`.
- On other accepted products, `acc` is updated to `acc + sext(P)`, with wrap in ACC_WIDTH.
- `state` is ignored after tap 0 of a group.

**Final tap** (accepted product with `tap_cnt == TAPS-1`)
- `sum = acc + sext(P)`.
- `sh` = ROW_SHIFT if `pass`, else COL_SHIFT.
- `r = (sum + (1 << (sh-1))) >>> sh`, arithmetic.
- `r` saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; on saturation, `sat_sticky` is set.
- `{r, idx_cnt}` is pushed into the buffer.
- `idx_cnt` increments modulo 64, wrapping 63 -> 0.
- `tap_cnt` returns to 0.

**Flow control**
- `p_ready = (tap_cnt != TAPS-1) || (buf_count < 2)`. It is registered-state only, with no combinational path from `out_ready`.

**Output buffer**
- 2-entry FIFO. The head drives `out_data`, `out_idx` and `out_last`.
- Pop on `out_valid && out_ready`.
- Push and pop in the same cycle are allowed. `buf_count` is unchanged and order is preserved.

**Flush**
- When `flush` = 1: `tap_cnt <= 0` and `acc <= 0`.
- A product presented in the same cycle is discarded, even on the final tap.
- `idx_cnt` and the buffer are untouched.
- `p_ready` is unaffected by `flush`.

## Timing
**Reset values** (while `rstN` = 0, asynchronously)
- `out_valid` = 0, `out_data` = 0, `out_idx` = 0, `out_last` = 0, `sat_sticky` = 0, `p_ready` = 1.
- Internally, `tap_cnt`, `idx_cnt`, `acc` and `buf_count` are all 0.

**Reset mid-group**
- Discards the partial sum and any buffered results.

**Latency**
- Final product accepted at edge N -> `out_valid` = 1 after edge N, when the buffer was empty. `out_data` is valid from edge N.

**Throughput**
- One product per cycle sustained while `out_ready` = 1.
- One result every TAPS cycles.

**Backpressure**
- With the buffer full, `p_ready` drops only while `tap_cnt == TAPS-1`.
- Taps 0..TAPS-2 of the next group continue to be accepted.
- `p_ready` rises the cycle after a pop.

**Handshake rules**
- `out_data`, `out_idx` and `out_last` are held stable while `out_valid && !out_ready`.
- `p_valid` may drop mid-group; the partial sum is retained indefinitely.

## Test plan
- **Row pass, basic:** `state` = 010, products 1,2,...,8, `out_ready` = 1 -> sum 36, `(36+4)>>>3` = 5; `out_data` = 5, `out_idx` = 0, `out_valid` for one cycle starting the edge after tap 8.
- **Column pass, rounding and sign:** `state` = 011, eight products of -40 -> sum -320, `(-320+32)>>>6` = -5; then eight products of 4 -> `(32+32)>>>6` = 1.
- **Saturation:** row pass, eight products of 0x0100_0000 -> `out_data` = 32767 and `sat_sticky` = 1; eight products of 0xF000_0000 -> `out_data` = -32768.
- **Backpressure:** `out_ready` = 0, three back-to-back groups -> two results buffered, `p_ready` = 0 at tap 7 of group 3. Raise `out_ready` -> head pops and `p_ready` = 1 the next cycle. All three results arrive in order with `out_idx` 0,1,2.
- **Index wrap:** 65 groups -> `out_last` = 1 only on `out_idx` 63; the 65th result has `out_idx` = 0.
- **Flush and reset mid-group:**
  - Flush after 5 products, with a valid product present in the flush cycle, then a full group of 8 ones -> single result `(8+4)>>>3` = 1.
  - Assert `rstN` low mid-group -> all outputs at reset values immediately.

Source files
------------

// File: rtl/idct_mac_accumulator_if.sv
// Product-in / result-out handshake bundle for the IDCT MAC accumulator.
interface idct_mac_accumulator_if #(
    parameter int OUT_WIDTH = 16
);
    logic [2:0]           state;
    logic [31:0]          P;
    logic                 p_valid;
    logic                 p_ready;
    logic                 flush;
    logic [OUT_WIDTH-1:0] out_data;
    logic [5:0]           out_idx;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sat_sticky;

    modport master (
        output state, P, p_valid, flush, out_ready,
        input  p_ready, out_data, out_idx, out_last, out_valid, sat_sticky
    );

    modport slave (
        input  state, P, p_valid, flush, out_ready,
        output p_ready, out_data, out_idx, out_last, out_valid, sat_sticky
    );
endinterface

// File: rtl/idct_mac_accumulator.sv
// Sums groups of TAPS products, applies pass-dependent rounding/shift/saturation
// and queues index-tagged results in a 2-entry output buffer.
module idct_mac_accumulator #(
    parameter int TAPS      = 8,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16,
    parameter int ROW_SHIFT = 3,
    parameter int COL_SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  rstN,
    idct_mac_accumulator_if.slave bus
);
    localparam int TAP_W = $clog2(TAPS);
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam int ENT_W = OUT_WIDTH + 7;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic signed [EXT_W-1:0] ROW_HALF = EXT_W'(64'sd1 <<< (ROW_SHIFT - 1));
    localparam logic signed [EXT_W-1:0] COL_HALF = EXT_W'(64'sd1 <<< (COL_SHIFT - 1));
    localparam logic signed [EXT_W-1:0] OUT_MAX  = EXT_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] OUT_MIN  = EXT_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    // Returns {saturated_flag, clamped_value}.
    function automatic logic [OUT_WIDTH:0] saturate_f(input logic signed [EXT_W-1:0] v);
        logic [OUT_WIDTH:0] res;
        if (v > OUT_MAX) begin
            res = {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        end else if (v < OUT_MIN) begin
            res = {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
        end else begin
            res = {1'b0, v[OUT_WIDTH-1:0]};
        end
        return res;
    endfunction

    logic [TAP_W-1:0]            tap_cnt_r, tap_cnt_n;
    logic signed [ACC_WIDTH-1:0] acc_r, acc_n;
    logic                        pass_r, pass_n;
    logic [5:0]                  idx_cnt_r, idx_cnt_n;
    logic [1:0]                  buf_count_r, buf_count_n;
    logic [ENT_W-1:0]            head_r, head_n, tail_r, tail_n;
    logic                        out_valid_r, out_valid_n;
    logic                        p_ready_r, p_ready_n;
    logic                        sat_sticky_r, sat_sticky_n;

    logic                        accept_s, push_s, pop_s;
    logic signed [ACC_WIDTH-1:0] psext_s, sum_s;
    logic signed [EXT_W-1:0]     sum_ext_s, rounded_s;
    logic [OUT_WIDTH:0]          sat_res_s;
    logic [ENT_W-1:0]            entry_s;

    assign accept_s  = bus.p_valid && p_ready_r && !bus.flush;
    assign push_s    = accept_s && (tap_cnt_r == LAST_TAP);
    assign pop_s     = out_valid_r && bus.out_ready;
    assign psext_s   = ACC_WIDTH'($signed(bus.P));
    assign sum_s     = acc_r + psext_s;
    assign sum_ext_s = EXT_W'(sum_s);
    assign sat_res_s = saturate_f(rounded_s);
    assign entry_s   = {sat_res_s[OUT_WIDTH-1:0], idx_cnt_r, (idx_cnt_r == 6'd63)};

    // Round-half-up and arithmetic shift of the completed group sum.
    always_comb begin
        rounded_s = '0;
        if (pass_r) begin
            rounded_s = (sum_ext_s + ROW_HALF) >>> ROW_SHIFT;
        end else begin
            rounded_s = (sum_ext_s + COL_HALF) >>> COL_SHIFT;
        end
    end

    // Next-state for the accumulator, tap/index counters and output buffer.
    always_comb begin
        tap_cnt_n    = tap_cnt_r;
        acc_n        = acc_r;
        pass_n       = pass_r;
        idx_cnt_n    = idx_cnt_r;
        buf_count_n  = buf_count_r;
        head_n       = head_r;
        tail_n       = tail_r;
        sat_sticky_n = sat_sticky_r | (push_s & sat_res_s[OUT_WIDTH]);

        if (bus.flush) begin
            tap_cnt_n = '0;
            acc_n     = '0;
        end else if (accept_s) begin
            if (tap_cnt_r == '0) begin
                acc_n  = psext_s;
                pass_n = (bus.state == 3'b010);
            end else begin
                acc_n  = sum_s;
            end
            if (tap_cnt_r == LAST_TAP) begin
                tap_cnt_n = '0;
                idx_cnt_n = idx_cnt_r + 6'd1;
            end else begin
                tap_cnt_n = tap_cnt_r + TAP_W'(1);
            end
        end else begin
            tap_cnt_n = tap_cnt_r;
        end

        // Push with a full buffer cannot happen: p_ready holds the final tap off.
        case (buf_count_r)
            2'd0: begin
                if (push_s) begin
                    head_n      = entry_s;
                    buf_count_n = 2'd1;
                end else begin
                    buf_count_n = 2'd0;
                end
            end
            2'd1: begin
                case ({push_s, pop_s})
                    2'b11:   head_n = entry_s;
                    2'b10: begin
                        tail_n      = entry_s;
                        buf_count_n = 2'd2;
                    end
                    2'b01:   buf_count_n = 2'd0;
                    default: buf_count_n = 2'd1;
                endcase
            end
            2'd2: begin
                if (pop_s) begin
                    head_n      = tail_r;
                    buf_count_n = 2'd1;
                end else begin
                    buf_count_n = 2'd2;
                end
            end
            default: buf_count_n = 2'd0;
        endcase

        out_valid_n = (buf_count_n != 2'd0);
        p_ready_n   = (tap_cnt_n != LAST_TAP) || (buf_count_n < 2'd2);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tap_cnt_r    <= '0;
            acc_r        <= '0;
            pass_r       <= 1'b0;
            idx_cnt_r    <= 6'd0;
            buf_count_r  <= 2'd0;
            head_r       <= '0;
            tail_r       <= '0;
            out_valid_r  <= 1'b0;
            p_ready_r    <= 1'b1;
            sat_sticky_r <= 1'b0;
        end else begin
            tap_cnt_r    <= tap_cnt_n;
            acc_r        <= acc_n;
            pass_r       <= pass_n;
            idx_cnt_r    <= idx_cnt_n;
            buf_count_r  <= buf_count_n;
            head_r       <= head_n;
            tail_r       <= tail_n;
            out_valid_r  <= out_valid_n;
            p_ready_r    <= p_ready_n;
            sat_sticky_r <= sat_sticky_n;
        end
    end

    assign bus.out_data   = head_r[ENT_W-1 -: OUT_WIDTH];
    assign bus.out_idx    = head_r[6:1];
    assign bus.out_last   = head_r[0];
    assign bus.out_valid  = out_valid_r;
    assign bus.p_ready    = p_ready_r;
    assign bus.sat_sticky = sat_sticky_r;
endmodule

// File: tb/tb_idct_mac_accumulator.sv
// Randomized and directed bench for idct_mac_accumulator against a group-level
// arithmetic reference model.
module tb_idct_mac_accumulator;
    localparam int TAPS      = 8;
    localparam int ACC_WIDTH = 40;
    localparam int OUT_WIDTH = 16;
    localparam int ROW_SHIFT = 3;
    localparam int COL_SHIFT = 6;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    int   checks = 0;
    int   errors = 0;

    idct_mac_accumulator_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

    idct_mac_accumulator #(
        .TAPS(TAPS), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .ROW_SHIFT(ROW_SHIFT), .COL_SHIFT(COL_SHIFT)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: products of the open group, expected buffer contents.
    int     grp_q[$];
    logic   grp_row;
    int     idx_m;
    logic   sat_m;
    longint exp_data_q[$];
    int     exp_idx_q[$];
    longint obs_data_q[$];
    int     obs_idx_q[$];
    int     obs_last_cnt;

    task automatic check_eq(input string tag, input logic signed [63:0] obsv,
                            input logic signed [63:0] expv);
        checks++;
        if (obsv !== expv) begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obsv, expv);
        end
    endtask

    task automatic close_group();
        longint s;
        longint r;
        int     sh;
        s = 0;
        foreach (grp_q[i]) s += longint'(grp_q[i]);
        s  = (s <<< (64 - ACC_WIDTH)) >>> (64 - ACC_WIDTH);
        sh = grp_row ? ROW_SHIFT : COL_SHIFT;
        r  = (s + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > 32767) begin
            r = 32767;
            sat_m = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            sat_m = 1'b1;
        end
        exp_data_q.push_back(r);
        exp_idx_q.push_back(idx_m);
        idx_m = (idx_m + 1) % 64;
        grp_q.delete();
    endtask

    task automatic clear_obs();
        obs_data_q.delete();
        obs_idx_q.delete();
        obs_last_cnt = 0;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model.
    task automatic step(input logic v, input logic [31:0] p, input logic [2:0] st,
                        input logic fl, input logic rdy, output logic took);
        logic exp_pready;
        logic do_pop;
        @(negedge clk);
        exp_pready = !((grp_q.size() == TAPS - 1) && (exp_data_q.size() == 2));
        check_eq("out_valid", bus.out_valid, exp_data_q.size() != 0);
        check_eq("p_ready", bus.p_ready, exp_pready);
        check_eq("sat_sticky", bus.sat_sticky, sat_m);
        if (exp_data_q.size() != 0) begin
            check_eq("out_data", $signed(bus.out_data), exp_data_q[0]);
            check_eq("out_idx", bus.out_idx, exp_idx_q[0]);
            check_eq("out_last", bus.out_last, exp_idx_q[0] == 63);
        end
        bus.p_valid   = v;
        bus.P         = p;
        bus.state     = st;
        bus.flush     = fl;
        bus.out_ready = rdy;
        do_pop = rdy && (exp_data_q.size() != 0);
        if (do_pop && bus.out_valid) begin
            obs_data_q.push_back($signed(bus.out_data));
            obs_idx_q.push_back(bus.out_idx);
            if (bus.out_last) obs_last_cnt++;
        end
        took = 1'b0;
        if (fl) begin
            grp_q.delete();
        end else if (v && exp_pready) begin
            took = 1'b1;
            if (grp_q.size() == 0) grp_row = (st == 3'b010);
            grp_q.push_back(int'(p));
        end
        if (do_pop) begin
            void'(exp_data_q.pop_front());
            void'(exp_idx_q.pop_front());
        end
        if (grp_q.size() == TAPS) close_group();
    endtask

    // Present a product until accepted; rmode 0 = never ready, 1 = always, 2 = random.
    task automatic feed(input logic [31:0] p, input logic [2:0] st, input int rmode);
        logic took;
        logic rdy;
        int   tries;
        tries = 0;
        took  = 1'b0;
        while (!took && tries < 40) begin
            rdy = (rmode == 1) || ((rmode == 2) && ($urandom_range(0, 3) != 0));
            step(1'b1, p, st, 1'b0, rdy, took);
            tries++;
        end
        check_eq("feed_accept", took, 1'b1);
    endtask

    task automatic idle(input int n);
        logic took;
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1, took);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.p_valid = 1'b0; bus.P = 32'd0; bus.state = 3'd0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        rstN = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_data", bus.out_data, 16'd0);
        check_eq("rst_out_idx", bus.out_idx, 6'd0);
        check_eq("rst_out_last", bus.out_last, 1'b0);
        check_eq("rst_sat_sticky", bus.sat_sticky, 1'b0);
        check_eq("rst_p_ready", bus.p_ready, 1'b1);
        grp_q.delete(); exp_data_q.delete(); exp_idx_q.delete();
        idx_m = 0; sat_m = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic took;
        grp_row = 1'b0; idx_m = 0; sat_m = 1'b0;
        clear_obs();
        do_reset();

        // Row pass 1..8 -> 5 at index 0.
        clear_obs();
        for (int i = 1; i <= TAPS; i++) feed(32'(i), 3'b010, 1);
        idle(3);
        check_eq("row_count", obs_data_q.size(), 1);
        if (obs_data_q.size() >= 1) begin
            check_eq("row_data", obs_data_q[0], 5);
            check_eq("row_idx", obs_idx_q[0], 0);
        end

        // Column pass; state after tap 0 is random and must be ignored.
        clear_obs();
        for (int i = 0; i < TAPS; i++) feed(-32'sd40, (i == 0) ? 3'b011 : 3'($urandom), 1);
        for (int i = 0; i < TAPS; i++) feed(32'd4, (i == 0) ? 3'b011 : 3'($urandom), 1);
        idle(3);
        check_eq("col_count", obs_data_q.size(), 2);
        if (obs_data_q.size() >= 2) begin
            check_eq("col_neg", obs_data_q[0], -5);
            check_eq("col_pos", obs_data_q[1], 1);
        end

        // Flush after 5 products with a valid product in the flush cycle.
        clear_obs();
        for (int i = 0; i < 5; i++) feed($urandom_range(0, 1000), 3'b010, 1);
        step(1'b1, 32'd77, 3'b010, 1'b1, 1'b1, took);
        check_eq("flush_discard", took, 1'b0);
        for (int i = 0; i < TAPS; i++) feed(32'd1, 3'b010, 1);
        idle(3);
        check_eq("flush_count", obs_data_q.size(), 1);
        if (obs_data_q.size() >= 1) check_eq("flush_data", obs_data_q[0], 1);

        // Saturation both ways.
        clear_obs();
        for (int i = 0; i < TAPS; i++) feed(32'h0100_0000, 3'b010, 1);
        for (int i = 0; i < TAPS; i++) feed(32'hF000_0000, 3'b010, 1);
        idle(3);
        check_eq("sat_count", obs_data_q.size(), 2);
        if (obs_data_q.size() >= 2) begin
            check_eq("sat_pos", obs_data_q[0], 32767);
            check_eq("sat_neg", obs_data_q[1], -32768);
        end
        check_eq("sat_sticky_set", bus.sat_sticky, 1'b1);

        // Reset in the middle of a group.
        for (int i = 0; i < 3; i++) feed($urandom, 3'b010, 1);
        do_reset();

        // Backpressure: three groups with the consumer stalled.
        clear_obs();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < TAPS; i++) feed($urandom, 3'($urandom), 0);
        for (int i = 0; i < TAPS - 1; i++) feed($urandom, 3'($urandom), 0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'd9, 3'b010, 1'b0, 1'b0, took);
            check_eq("bp_stall", took, 1'b0);
        end
        feed(32'd9, 3'b010, 1);
        idle(5);
        check_eq("bp_count", obs_data_q.size(), 3);
        for (int k = 0; k < obs_idx_q.size(); k++) check_eq("bp_order", obs_idx_q[k], k);

        // Index wrap over 65 random groups with random gaps and backpressure.
        do_reset();
        clear_obs();
        for (int g = 0; g < 65; g++)
            for (int i = 0; i < TAPS; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    step(1'b0, $urandom, 3'($urandom), 1'b0, 1'($urandom), took);
                end
                feed($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4000)),
                     3'($urandom_range(2, 3)), 2);
            end
        idle(6);
        check_eq("wrap_count", obs_data_q.size(), 65);
        check_eq("wrap_last_cnt", obs_last_cnt, 1);
        if (obs_idx_q.size() == 65) begin
            check_eq("wrap_idx63", obs_idx_q[63], 63);
            check_eq("wrap_idx64", obs_idx_q[64], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
